// File: rtl/operand_forward_unit_pkg.sv
// Shared definitions for the operand forwarding unit: forward-source codes and
// the bit layout of one EX/MEM/WB scoreboard entry.
package operand_forward_unit_pkg;

    localparam int FWD_SEL_WIDTH = 2;

    typedef enum logic [FWD_SEL_WIDTH-1:0] {
        FWD_SEL_ID  = 2'd0,
        FWD_SEL_EX  = 2'd1,
        FWD_SEL_MEM = 2'd2,
        FWD_SEL_WB  = 2'd3
    } fwd_sel_e;

    // Scoreboard entry: {addr, is_load, we, valid}, valid at bit 0.
    localparam int SB_VALID_BIT = 0;
    localparam int SB_WE_BIT    = 1;
    localparam int SB_LOAD_BIT  = 2;
    localparam int SB_ADDR_LSB  = 3;

    function automatic int sb_entry_width(input int addr_width);
        return SB_ADDR_LSB + addr_width;
    endfunction

endpackage

// File: rtl/operand_forward_unit_sel.sv
// Per-operand forwarding mux: finds the newest in-flight producer of one source
// register and flags when that producer is a load still sitting in EX.
module fwd_operand_sel
    import operand_forward_unit_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int RF_ADDR_WIDTH = 3,
    parameter int ZERO_REG_EN   = 1
) (
    input  logic [RF_ADDR_WIDTH-1:0]             i_src_addr,
    input  logic [DATA_WIDTH-1:0]                i_src_data,
    input  logic [RF_ADDR_WIDTH+SB_ADDR_LSB-1:0] i_ex_entry,
    input  logic [RF_ADDR_WIDTH+SB_ADDR_LSB-1:0] i_mem_entry,
    input  logic [RF_ADDR_WIDTH+SB_ADDR_LSB-1:0] i_wb_entry,
    input  logic [DATA_WIDTH-1:0]                i_ex_result,
    input  logic [DATA_WIDTH-1:0]                i_mem_result,
    input  logic [DATA_WIDTH-1:0]                i_wb_result,
    output logic [FWD_SEL_WIDTH-1:0]             o_sel,
    output logic [DATA_WIDTH-1:0]                o_data,
    output logic                                 o_load_hit
);

    localparam int SB_W = RF_ADDR_WIDTH + SB_ADDR_LSB;

    function automatic logic entry_hit(input logic [SB_W-1:0] e, input logic [RF_ADDR_WIDTH-1:0] a);
        return e[SB_VALID_BIT] && e[SB_WE_BIT] && (e[SB_ADDR_LSB +: RF_ADDR_WIDTH] == a);
    endfunction

    logic w_is_zero;
    logic w_sel_is_load;

    assign w_is_zero = (ZERO_REG_EN != 0) && (i_src_addr == '0);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_sel         = FWD_SEL_ID;
        o_data        = i_src_data;
        w_sel_is_load = 1'b0;
        if (w_is_zero) begin
            o_data = '0;
        end else if (entry_hit(i_ex_entry, i_src_addr)) begin
            o_sel         = FWD_SEL_EX;
            o_data        = i_ex_result;
            w_sel_is_load = i_ex_entry[SB_LOAD_BIT];
        end else if (entry_hit(i_mem_entry, i_src_addr)) begin
            o_sel         = FWD_SEL_MEM;
            o_data        = i_mem_result;
            w_sel_is_load = i_mem_entry[SB_LOAD_BIT];
        end else if (entry_hit(i_wb_entry, i_src_addr)) begin
            o_sel         = FWD_SEL_WB;
            o_data        = i_wb_result;
            w_sel_is_load = i_wb_entry[SB_LOAD_BIT];
        end
    end

    // Load data is only unavailable while the load is still in EX.
    assign o_load_hit = w_sel_is_load && (o_sel == FWD_SEL_EX);

endmodule

// File: rtl/operand_forward_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destinations, muxes the
// newest value per source operand and registers the result into ID/EX.
module operand_forward_unit
    import operand_forward_unit_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int RF_ADDR_WIDTH = 3,
    parameter int NUM_OPS       = 2,
    parameter int ZERO_REG_EN   = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic [NUM_OPS*RF_ADDR_WIDTH-1:0]   id_src_addr,
    input  logic [NUM_OPS*DATA_WIDTH-1:0]      id_src_data,
    input  logic [RF_ADDR_WIDTH-1:0]           id_dst_addr,
    input  logic                               id_dst_we,
    input  logic                               id_is_load,
    input  logic [DATA_WIDTH-1:0]              ex_result,
    input  logic [DATA_WIDTH-1:0]              mem_result,
    input  logic [DATA_WIDTH-1:0]              wb_result,
    input  logic                               flush,
    input  logic                               hold,
    output logic                               stall_out,
    output logic                               ex_valid,
    output logic [NUM_OPS*DATA_WIDTH-1:0]      ex_op_data,
    output logic [NUM_OPS*FWD_SEL_WIDTH-1:0]   ex_fwd_sel,
    output logic [RF_ADDR_WIDTH-1:0]           ex_dst_addr,
    output logic                               ex_dst_we,
    output logic [CNT_WIDTH-1:0]               stall_cnt
);

    localparam int SB_W = sb_entry_width(RF_ADDR_WIDTH);

    logic [SB_W-1:0]                  r_sb_ex, r_sb_mem, r_sb_wb;
    logic                             r_ex_valid;
    logic [NUM_OPS*DATA_WIDTH-1:0]    r_ex_op_data;
    logic [NUM_OPS*FWD_SEL_WIDTH-1:0] r_ex_fwd_sel;
    logic [RF_ADDR_WIDTH-1:0]         r_ex_dst_addr;
    logic                             r_ex_dst_we;
    logic [CNT_WIDTH-1:0]             r_stall_cnt;

    logic [NUM_OPS-1:0]               w_load_hit;
    logic [NUM_OPS*DATA_WIDTH-1:0]    w_op_data;
    logic [NUM_OPS*FWD_SEL_WIDTH-1:0] w_op_sel;
    logic                             w_issue;
    logic                             w_dst_we;
    logic [SB_W-1:0]                  w_sb_next;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
        fwd_operand_sel #(
            .DATA_WIDTH    (DATA_WIDTH),
            .RF_ADDR_WIDTH (RF_ADDR_WIDTH),
            .ZERO_REG_EN   (ZERO_REG_EN)
        ) u_sel (
            .i_src_addr   (id_src_addr[k*RF_ADDR_WIDTH +: RF_ADDR_WIDTH]),
            .i_src_data   (id_src_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_ex_entry   (r_sb_ex),
            .i_mem_entry  (r_sb_mem),
            .i_wb_entry   (r_sb_wb),
            .i_ex_result  (ex_result),
            .i_mem_result (mem_result),
            .i_wb_result  (wb_result),
            .o_sel        (w_op_sel[k*FWD_SEL_WIDTH +: FWD_SEL_WIDTH]),
            .o_data       (w_op_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_load_hit   (w_load_hit[k])
        );
    end

    // A flushed instruction is discarded, so it never needs to wait on a load.
    assign stall_out = id_valid && (|w_load_hit) && !flush;
    assign w_issue   = id_valid && !stall_out && !flush && !hold;
    assign w_dst_we  = id_dst_we && !((ZERO_REG_EN != 0) && (id_dst_addr == '0));

    always_comb begin
        w_sb_next = '0;
        if (w_issue) begin
            w_sb_next[SB_VALID_BIT]                      = 1'b1;
            w_sb_next[SB_WE_BIT]                         = w_dst_we;
            w_sb_next[SB_LOAD_BIT]                       = id_is_load;
            w_sb_next[SB_ADDR_LSB +: RF_ADDR_WIDTH]      = id_dst_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the EX->MEM->WB shift reads pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_ex       <= '0;
            r_sb_mem      <= '0;
            r_sb_wb       <= '0;
            r_ex_valid    <= 1'b0;
            r_ex_op_data  <= '0;
            r_ex_fwd_sel  <= '0;
            r_ex_dst_addr <= '0;
            r_ex_dst_we   <= 1'b0;
            r_stall_cnt   <= '0;
        end else if (!hold) begin
            r_sb_ex    <= w_sb_next;
            r_sb_mem   <= r_sb_ex;
            r_sb_wb    <= r_sb_mem;
            r_ex_valid <= w_issue;
            if (w_issue) begin
                r_ex_op_data  <= w_op_data;
                r_ex_fwd_sel  <= w_op_sel;
                r_ex_dst_addr <= id_dst_addr;
                r_ex_dst_we   <= w_dst_we;
            end else begin
                r_ex_dst_we   <= 1'b0;
            end
            if (stall_out && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_op_data  = r_ex_op_data;
    assign ex_fwd_sel  = r_ex_fwd_sel;
    assign ex_dst_addr = r_ex_dst_addr;
    assign ex_dst_we   = r_ex_dst_we;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Self-checking bench for operand_forward_unit: directed scenarios plus random
// traffic compared against an in-flight instruction list model.
module tb_operand_forward_unit;

    localparam int D = 16;
    localparam int A = 3;
    localparam int N = 2;
    localparam int C = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [N*A-1:0]   id_src_addr;
    logic [N*D-1:0]   id_src_data;
    logic [A-1:0]     id_dst_addr;
    logic             id_dst_we;
    logic             id_is_load;
    logic [D-1:0]     ex_result, mem_result, wb_result;
    logic             flush, hold;
    logic             stall_out;
    logic             ex_valid;
    logic [N*D-1:0]   ex_op_data;
    logic [N*2-1:0]   ex_fwd_sel;
    logic [A-1:0]     ex_dst_addr;
    logic             ex_dst_we;
    logic [C-1:0]     stall_cnt;

    int errors = 0;
    int checks = 0;

    operand_forward_unit #(
        .DATA_WIDTH(D), .RF_ADDR_WIDTH(A), .NUM_OPS(N), .ZERO_REG_EN(1), .CNT_WIDTH(C)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_data(id_src_data), .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .id_is_load(id_is_load), .ex_result(ex_result), .mem_result(mem_result),
        .wb_result(wb_result), .flush(flush), .hold(hold), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_op_data(ex_op_data), .ex_fwd_sel(ex_fwd_sel),
        .ex_dst_addr(ex_dst_addr), .ex_dst_we(ex_dst_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the last three pipeline slots, index 0 = youngest (EX).
    typedef struct {
        bit v;
        bit we;
        bit ld;
        int addr;
    } slot_t;

    slot_t          pipe[3];
    logic           exp_stall;
    logic [N*D-1:0] fwd_data;
    logic [N*2-1:0] fwd_sel;
    logic           exp_valid;
    logic [N*D-1:0] exp_data;
    logic [N*2-1:0] exp_sel;
    logic [A-1:0]   exp_dst;
    logic           exp_we;
    logic [C-1:0]   exp_cnt;

    function automatic logic [D-1:0] stage_result(input int s);
        case (s)
            0:       return ex_result;
            1:       return mem_result;
            default: return wb_result;
        endcase
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++) pipe[s] = '{v: 0, we: 0, ld: 0, addr: 0};
        exp_valid = 0; exp_data = '0; exp_sel = '0; exp_dst = '0; exp_we = 0; exp_cnt = '0;
    endtask

    // Newest producer wins: walk from oldest to youngest so later hits overwrite.
    task automatic model_eval();
        bit need_stall;
        need_stall = 0;
        for (int k = 0; k < N; k++) begin
            int src;
            src = int'(id_src_addr[k*A +: A]);
            fwd_data[k*D +: D] = (src == 0) ? '0 : id_src_data[k*D +: D];
            fwd_sel[k*2 +: 2]  = 2'd0;
            if (src != 0) begin
                for (int s = 2; s >= 0; s--) begin
                    if (pipe[s].v && pipe[s].we && pipe[s].addr == src) begin
                        fwd_data[k*D +: D] = stage_result(s);
                        fwd_sel[k*2 +: 2]  = 2'(s + 1);
                    end
                end
                if (pipe[0].v && pipe[0].we && pipe[0].ld && pipe[0].addr == src) need_stall = 1;
            end
        end
        exp_stall = id_valid && need_stall && !flush;
    endtask

    task automatic model_step();
        bit issue;
        bit we_eff;
        if (rst) begin
            model_reset();
            return;
        end
        model_eval();
        if (hold) return;
        issue  = id_valid && !exp_stall && !flush;
        we_eff = id_dst_we && (id_dst_addr != 0);
        if (exp_stall && exp_cnt != {C{1'b1}}) exp_cnt = exp_cnt + 1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = issue ? '{v: 1, we: we_eff, ld: id_is_load, addr: int'(id_dst_addr)}
                        : '{v: 0, we: 0, ld: 0, addr: 0};
        exp_valid = issue;
        if (issue) begin
            exp_data = fwd_data;
            exp_sel  = fwd_sel;
            exp_dst  = id_dst_addr;
            exp_we   = we_eff;
        end else begin
            exp_we = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_id(input bit v, input int dst, input bit we, input bit ld,
                          input int s0, input logic [D-1:0] d0, input int s1, input logic [D-1:0] d1);
        id_valid    = v;
        id_dst_addr = dst[A-1:0];
        id_dst_we   = we;
        id_is_load  = ld;
        id_src_addr = {s1[A-1:0], s0[A-1:0]};
        id_src_data = {d1, d0};
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; hold = 0;
        set_id(0, 0, 0, 0, 0, '0, 0, '0);
        ex_result = '0; mem_result = '0; wb_result = '0;
        model_reset();
        #2;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
        checks++; if (ex_op_data !== '0) begin errors++; $display("FAIL reset_op_data: got %h want 0", ex_op_data); end
        checks++; if (ex_fwd_sel !== '0) begin errors++; $display("FAIL reset_fwd_sel: got %b want 0", ex_fwd_sel); end
        checks++; if (ex_dst_we !== 1'b0 || ex_dst_addr !== '0) begin errors++; $display("FAIL reset_dst: got %b/%h want 0/0", ex_dst_we, ex_dst_addr); end
        checks++; if (stall_cnt !== '0 || stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0d/%b want 0/0", stall_cnt, stall_out); end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        set_id(1, 3, 1, 0, 1, 16'h1111, 2, 16'h2222);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_dst_addr !== 3'd3 || ex_dst_we !== 1'b1) begin errors++; $display("FAIL b2b_issue: got v=%b dst=%0d we=%b want 1/3/1", ex_valid, ex_dst_addr, ex_dst_we); end
        set_id(1, 4, 0, 0, 3, 16'hDEAD, 1, 16'h3333);
        ex_result = 16'h00AA;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", stall_out); end
        tick();
        checks++; if (ex_op_data !== {16'h3333, 16'h00AA}) begin errors++; $display("FAIL b2b_data: got %h want 333300aa", ex_op_data); end
        checks++; if (ex_fwd_sel !== 4'b0001) begin errors++; $display("FAIL b2b_sel: got %b want 0001", ex_fwd_sel); end
    endtask

    task automatic test_distance();
        ex_result = 16'h0BAD; mem_result = 16'h1234; wb_result = 16'h5678;
        set_id(1, 5, 1, 0, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 5, 1, 0, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 7, 1, 0, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 1, 0, 0, 5, 16'hFFFF, 6, 16'h6666); tick();
        checks++; if (ex_op_data !== {16'h6666, 16'h1234} || ex_fwd_sel !== 4'b0010) begin errors++; $display("FAIL dist_mem: got %h sel %b want 66661234 sel 0010", ex_op_data, ex_fwd_sel); end
        set_id(1, 5, 1, 0, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 7, 1, 0, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 6, 0, 0, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 1, 0, 0, 5, 16'hFFFF, 6, 16'h6666); tick();
        checks++; if (ex_op_data !== {16'h6666, 16'h5678} || ex_fwd_sel !== 4'b0011) begin errors++; $display("FAIL dist_wb: got %h sel %b want 66665678 sel 0011", ex_op_data, ex_fwd_sel); end
    endtask

    task automatic test_load_use();
        mem_result = 16'h4321;
        set_id(1, 2, 1, 1, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 3, 1, 0, 7, 16'h7777, 2, 16'h2020);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall_out); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_dst_we !== 1'b0) begin errors++; $display("FAIL lu_bubble: got v=%b we=%b want 0/0", ex_valid, ex_dst_we); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", stall_out); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op_data !== {16'h4321, 16'h7777} || ex_fwd_sel !== 4'b1000) begin errors++; $display("FAIL lu_fwd: got v=%b %h sel %b want 1 43217777 sel 1000", ex_valid, ex_op_data, ex_fwd_sel); end
    endtask

    task automatic test_zero_reg();
        set_id(1, 0, 1, 1, 1, 16'h0, 1, 16'h0); tick();
        checks++; if (ex_valid !== 1'b1 || ex_dst_we !== 1'b0) begin errors++; $display("FAIL zero_dst_we: got v=%b we=%b want 1/0", ex_valid, ex_dst_we); end
        ex_result = 16'hABCD;
        set_id(1, 3, 0, 0, 0, 16'hFFFF, 0, 16'hEEEE);
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b want 0", stall_out); end
        tick();
        checks++; if (ex_op_data !== '0 || ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL zero_data: got %h sel %b want 0 sel 0000", ex_op_data, ex_fwd_sel); end
    endtask

    task automatic test_flush_hold();
        mem_result = 16'h9999;
        set_id(1, 4, 1, 1, 1, 16'h0, 1, 16'h0); tick();
        set_id(1, 5, 1, 0, 4, 16'h4444, 3, 16'h3333);
        flush = 1;
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall_out); end
        tick();
        flush = 0;
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_bubble: got v=%b cnt=%0d want 0/1", ex_valid, stall_cnt); end
        set_id(1, 4, 1, 1, 1, 16'h1010, 1, 16'h1010); tick();
        set_id(1, 5, 1, 0, 4, 16'h4444, 3, 16'h3333);
        hold = 1;
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b want 1", stall_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ex_valid !== 1'b1 || ex_op_data !== {16'h1010, 16'h1010} || ex_fwd_sel !== 4'b0000 ||
                ex_dst_addr !== 3'd4 || ex_dst_we !== 1'b1 || stall_cnt !== 16'd1) begin
                errors++;
                $display("FAIL hold_freeze%0d: got v=%b %h sel %b dst %0d we %b cnt %0d want 1 10101010 0000 4 1 1",
                         i, ex_valid, ex_op_data, ex_fwd_sel, ex_dst_addr, ex_dst_we, stall_cnt);
            end
        end
        hold = 0;
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL hold_resume_stall: got %b want 1", stall_out); end
        tick();
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd2) begin errors++; $display("FAIL hold_resume_bubble: got v=%b cnt=%0d want 0/2", ex_valid, stall_cnt); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op_data !== {16'h3333, 16'h9999} || ex_fwd_sel !== 4'b0010) begin errors++; $display("FAIL hold_resume_fwd: got v=%b %h sel %b want 1 33339999 0010", ex_valid, ex_op_data, ex_fwd_sel); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3), D'($urandom), $urandom_range(0, 3), D'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            ex_result = D'($urandom); mem_result = D'($urandom); wb_result = D'($urandom);
            #1;
            model_eval();
            checks++; if (stall_out !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", n, stall_out, exp_stall); end
            tick();
            checks++; if (ex_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, ex_valid, exp_valid); end
            checks++; if (ex_op_data !== exp_data) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, ex_op_data, exp_data); end
            checks++; if (ex_fwd_sel !== exp_sel) begin errors++; $display("FAIL rnd_sel@%0d: got %b want %b", n, ex_fwd_sel, exp_sel); end
            checks++; if (ex_dst_addr !== exp_dst || ex_dst_we !== exp_we) begin errors++; $display("FAIL rnd_dst@%0d: got %0d/%b want %0d/%b", n, ex_dst_addr, ex_dst_we, exp_dst, exp_we); end
            checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, stall_cnt, exp_cnt); end
        end
        flush = 0;
        hold  = 0;
    endtask

    task automatic test_reset_midstream();
        set_id(1, 2, 1, 1, 1, 16'h0, 2, 16'h0); tick();
        set_id(1, 3, 1, 0, 2, 16'h1111, 2, 16'h2222);
        #2;
        rst = 1;
        #1;
        model_reset();
        checks++;
        if (ex_valid !== 1'b0 || ex_op_data !== '0 || ex_fwd_sel !== '0 || ex_dst_addr !== '0 ||
            ex_dst_we !== 1'b0 || stall_cnt !== '0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: got v=%b %h sel %b dst %0d we %b cnt %0d st %b want all 0",
                     ex_valid, ex_op_data, ex_fwd_sel, ex_dst_addr, ex_dst_we, stall_cnt, stall_out);
        end
        #2;
        rst = 0;
        set_id(1, 1, 1, 0, 3, 16'hBEEF, 6, 16'h0102);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op_data !== {16'h0102, 16'hBEEF} || ex_fwd_sel !== 4'b0000) begin errors++; $display("FAIL midreset_first: got v=%b %h sel %b want 1 0102beef 0000", ex_valid, ex_op_data, ex_fwd_sel); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_zero_reg();
        test_flush_hold();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
